// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester round-robin arbiter for a single-port RAM
// Grants one access per cycle with bounded burst ownership and routes read data back.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  gnt_a,
  output logic                  rvalid_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_b,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MB_CNT = CW'(MAX_BURST);

  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

  owner_t        owner;
  logic [CW-1:0] cnt;
  logic          last_b;
  logic          rv_a;
  logic          rv_b;
  logic          sel_a;
  logic          sel_b;

  always_comb begin
    sel_a = 1'b0;
    sel_b = 1'b0;
    if (req_a && !req_b) begin
      sel_a = 1'b1;
    end else if (req_b && !req_a) begin
      sel_b = 1'b1;
    end else if (req_a && req_b) begin
      // Current owner keeps the port until its burst allowance is used up.
      if (owner == OWN_A && cnt < MB_CNT) begin
        sel_a = 1'b1;
      end else if (owner == OWN_B && cnt < MB_CNT) begin
        sel_b = 1'b1;
      end else if (last_b) begin
        sel_a = 1'b1;
      end else begin
        sel_b = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_a    = rst_n & sel_a;
    gnt_b    = rst_n & sel_b;
    rvalid_a = rst_n & rv_a;
    rvalid_b = rst_n & rv_b;
    rdata    = '0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    if (rst_n) begin
      if (rv_a || rv_b) begin
        rdata = ram_q;
      end
      if (sel_a) begin
        ram_we   = we_a;
        ram_addr = addr_a;
        ram_data = wdata_a;
      end else if (sel_b) begin
        ram_we   = we_b;
        ram_addr = addr_b;
        ram_data = wdata_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner  <= OWN_NONE;
      cnt    <= '0;
      last_b <= 1'b1;
      rv_a   <= 1'b0;
      rv_b   <= 1'b0;
    end else begin
      rv_a <= sel_a & ~we_a;
      rv_b <= sel_b & ~we_b;
      if (sel_a || sel_b) begin
        if ((sel_a && owner == OWN_A) || (sel_b && owner == OWN_B)) begin
          if (cnt != MB_CNT) begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          cnt <= CW'(1);
        end
        owner  <= sel_a ? OWN_A : OWN_B;
        last_b <= sel_b;
      end else begin
        owner <= OWN_NONE;
        cnt   <= '0;
      end
    end
  end

endmodule
